// File: rtl/nbody_step_scheduler.sv
// Sequences one n-body time step: clear accelerations, walk all i<j pairs, then integrate every body.
// Optional completed-step counter on STEP_COUNT is enabled by defining NBODY_STEP_COUNT_EN.
module nbody_step_scheduler #(
   parameter int MAX_BODIES = 10,
   parameter int IDX_W      = 4
) (
   input  logic              CLK,
   input  logic              RESET,
   input  logic              START,
   input  logic [31:0]       PLANET_NUM,
   output logic              CLEAR_ACCS,
   output logic              PAIR_VALID,
   output logic [IDX_W-1:0]  PAIR_I,
   output logic [IDX_W-1:0]  PAIR_J,
   input  logic              PAIR_READY,
   output logic              INT_VALID,
   output logic [IDX_W-1:0]  INT_IDX,
   input  logic              INT_READY,
   output logic              BUSY,
   output logic              DONE,
   output logic [15:0]       STEP_COUNT
);

   // One extra bit so the body count can represent MAX_BODIES itself.
   localparam int N_W = IDX_W + 1;

   typedef enum logic [2:0] {
      S_IDLE      = 3'd0,
      S_CLEAR     = 3'd1,
      S_PAIRS     = 3'd2,
      S_INTEGRATE = 3'd3,
      S_FINISH    = 3'd4,
      S_DONE_WAIT = 3'd5
   } state_t;

   state_t           state_r;
   logic [N_W-1:0]   n_r;
   logic [N_W-1:0]   n_clamp_s;
   logic [IDX_W-1:0] i_r;
   logic [IDX_W-1:0] j_r;
   logic [IDX_W-1:0] k_r;

   assign PAIR_I  = i_r;
   assign PAIR_J  = j_r;
   assign INT_IDX = k_r;

   // Clamp the requested body count against the full 32-bit register value.
   always_comb begin
      if (PLANET_NUM > 32'(MAX_BODIES)) begin
         n_clamp_s = N_W'(MAX_BODIES);
      end else begin
         n_clamp_s = PLANET_NUM[N_W-1:0];
      end
   end

   // Step sequencer with registered handshake and status outputs.
   always_ff @(posedge CLK) begin
      if (RESET) begin
         state_r    <= S_IDLE;
         n_r        <= {N_W{1'b0}};
         i_r        <= {IDX_W{1'b0}};
         j_r        <= {IDX_W{1'b0}};
         k_r        <= {IDX_W{1'b0}};
         CLEAR_ACCS <= 1'b0;
         PAIR_VALID <= 1'b0;
         INT_VALID  <= 1'b0;
         BUSY       <= 1'b0;
         DONE       <= 1'b0;
      end else begin
         case (state_r)
            S_IDLE: begin
               if (START) begin
                  n_r        <= n_clamp_s;
                  i_r        <= {IDX_W{1'b0}};
                  j_r        <= {IDX_W{1'b0}};
                  k_r        <= {IDX_W{1'b0}};
                  CLEAR_ACCS <= 1'b1;
                  BUSY       <= 1'b1;
                  state_r    <= S_CLEAR;
               end
            end
            S_CLEAR: begin
               CLEAR_ACCS <= 1'b0;
               i_r        <= {IDX_W{1'b0}};
               j_r        <= IDX_W'(1);
               k_r        <= {IDX_W{1'b0}};
               if (n_r >= N_W'(2)) begin
                  PAIR_VALID <= 1'b1;
                  state_r    <= S_PAIRS;
               end else if (n_r == N_W'(1)) begin
                  INT_VALID  <= 1'b1;
                  state_r    <= S_INTEGRATE;
               end else begin
                  state_r    <= S_FINISH;
               end
            end
            S_PAIRS: begin
               // Indices only move on an accepted pair; j restarts just above the new i.
               if (PAIR_READY) begin
                  if ({1'b0, j_r} < (n_r - N_W'(1))) begin
                     j_r <= j_r + IDX_W'(1);
                  end else if ({1'b0, i_r} < (n_r - N_W'(2))) begin
                     i_r <= i_r + IDX_W'(1);
                     j_r <= i_r + IDX_W'(2);
                  end else begin
                     PAIR_VALID <= 1'b0;
                     INT_VALID  <= 1'b1;
                     state_r    <= S_INTEGRATE;
                  end
               end
            end
            S_INTEGRATE: begin
               if (INT_READY) begin
                  if ({1'b0, k_r} == (n_r - N_W'(1))) begin
                     INT_VALID <= 1'b0;
                     state_r   <= S_FINISH;
                  end else begin
                     k_r <= k_r + IDX_W'(1);
                  end
               end
            end
            S_FINISH: begin
               BUSY    <= 1'b0;
               DONE    <= 1'b1;
               state_r <= S_DONE_WAIT;
            end
            S_DONE_WAIT: begin
               // Holding START high must not retrigger; wait for software to clear it.
               if (!START) begin
                  DONE    <= 1'b0;
                  state_r <= S_IDLE;
               end
            end
            default: begin
               state_r    <= S_IDLE;
               CLEAR_ACCS <= 1'b0;
               PAIR_VALID <= 1'b0;
               INT_VALID  <= 1'b0;
               BUSY       <= 1'b0;
               DONE       <= 1'b0;
            end
         endcase
      end
   end

`ifdef NBODY_STEP_COUNT_EN
   logic [15:0] step_cnt_r;

   // Completed-step counter, advanced once per FINISH cycle and wrapping at 16 bits.
   always_ff @(posedge CLK) begin
      if (RESET) begin
         step_cnt_r <= 16'h0000;
      end else if (state_r == S_FINISH) begin
         step_cnt_r <= step_cnt_r + 16'h0001;
      end else begin
         step_cnt_r <= step_cnt_r;
      end
   end

   assign STEP_COUNT = step_cnt_r;
`else
   assign STEP_COUNT = 16'h0000;
`endif

endmodule

// File: doc/nbody_step_scheduler.md
Name: nbody_step_scheduler

Overview:
Sequences one physics time-step over the body register file. It clears the acceleration banks, then walks every unordered body pair (i<j) through the force datapath, then walks every body through the integrator. Start and done are level bits in the Avalon register map, so software can trigger steps and poll for completion. The block owns no arithmetic; it only issues indices and handshakes to the datapath units that share the register file.

Parameters:
MAX_BODIES, 10, register-file capacity per variable bank; the body count is clamped to this value.
IDX_W, 4, width of body index outputs; must satisfy 2^IDX_W >= MAX_BODIES.

Ports:
CLK  in  1  system clock, 50 MHz
RESET  in  1  reset; synchronous, active-high
START  in  1  level start bit from the register map (START register bit 0)
PLANET_NUM  in  32  requested body count from the register map
CLEAR_ACCS  out  1  one-cycle pulse; the register file zeroes all ACC_X/Y/Z entries
PAIR_VALID  out  1  pair request to the force datapath
PAIR_I  out  IDX_W  first body index
PAIR_J  out  IDX_W  second body index, always > PAIR_I
PAIR_READY  in  1  force datapath accepts the pair
INT_VALID  out  1  integrate request to the integrator
INT_IDX  out  IDX_W  body index to integrate
INT_READY  in  1  integrator accepts the index
BUSY  out  1  high in every state except IDLE and DONE_WAIT
DONE  out  1  step complete; written to DONE register bit 0
STEP_COUNT  out  16  count of completed steps (optional feature)

Behaviour:
- Reset: state IDLE, all outputs 0, index counters 0, latched N = 0. Asserting RESET in any state aborts the step on that edge with no further pulses.
- States: IDLE, CLEAR, PAIRS, INTEGRATE, FINISH, DONE_WAIT.
- IDLE:
  - When START is sampled 1, latch N = min(PLANET_NUM, MAX_BODIES) and go to CLEAR.
  - PLANET_NUM and its upper bits are compared as an unsigned full 32-bit value before clamping.
- CLEAR:
  - CLEAR_ACCS = 1 for exactly this one cycle.
  - Next state: PAIRS if N >= 2; INTEGRATE if N == 1; FINISH if N == 0.
  - Set i = 0 and j = 1.
- PAIRS:
  - PAIR_VALID = 1 with PAIR_I = i and PAIR_J = j.
  - Index values hold stable until PAIR_READY is sampled 1. PAIR_VALID never drops without a handshake.
  - On each handshake: if j < N-1 then j++. Otherwise, if i < N-2 then i++ and j = i+2. Otherwise go to INTEGRATE.
  - Order is (0,1), (0,2) … (0,N-1), (1,2) … (N-2,N-1), giving N(N-1)/2 pairs.
- INTEGRATE:
  - INT_VALID = 1 with INT_IDX = k, k from 0 to N-1, one index per INT_READY handshake.
  - After k = N-1 is accepted, go to FINISH.
- FINISH:
  - Lasts one cycle, then DONE = 1 (registered) and go to DONE_WAIT.
- DONE_WAIT:
  - DONE stays 1 until START is sampled 0; then DONE = 0 and go to IDLE.
  - Because of this, one START level runs exactly one step. Software must clear START before re-arming.
- Timing:
  - Best case (READY tied 1): START sampled at edge 0 → CLEAR_ACCS high in cycle 1 → first PAIR_VALID in cycle 2.
  - One handshake per cycle thereafter.
- Changes to PLANET_NUM mid-step are ignored; N is latched.
- PAIR_VALID and INT_VALID are never high simultaneously, and neither is high in the CLEAR_ACCS cycle.
- READY inputs are ignored while the matching VALID is 0.

Optional Feature:
Macro NBODY_STEP_COUNT_EN.
- Defined: STEP_COUNT resets to 0 and increments by 1 on each FINISH cycle, wrapping from 0xFFFF to 0x0000.
- Undefined: STEP_COUNT is tied to 0 and no counter is synthesised.

Test Plan:
- N=4, both READY tied 1, START=1 at edge 0 → CLEAR_ACCS pulse in cycle 1; pairs (0,1),(0,2),(0,3),(1,2),(1,3),(2,3) in cycles 2–7; INT_IDX 0–3 in cycles 8–11; FINISH in cycle 12; DONE=1 from cycle 13.
- N=3 with PAIR_READY low for 3 cycles on pair (0,2) → PAIR_VALID, PAIR_I=0 and PAIR_J=2 hold all 3 cycles; 3 pairs total in order; no INT_VALID until the last pair is accepted.
- PLANET_NUM=1 → CLEAR_ACCS pulse, no PAIR_VALID, a single INT_IDX=0 handshake, then DONE. PLANET_NUM=0 → CLEAR pulse then DONE with no VALIDs. PLANET_NUM=0x8000000A → clamped to 10, giving 45 pairs and 10 integrates.
- START held 1 after DONE → no second CLEAR_ACCS pulse. Drop START → DONE falls one cycle later. Re-raise START → a new step starts.
- RESET asserted during PAIRS at pair (1,2) → next cycle all outputs 0 and state IDLE. With START still 1 after reset, a fresh step restarts at pair (0,1).
- With NBODY_STEP_COUNT_EN defined, run 3 steps → STEP_COUNT=3. Preload the counter to 0xFFFF via forced state and run 1 step → STEP_COUNT=0.
